spio_uart_tx_framer: RTL and testbench

SPIO_UART_TX_FRAMER -- requirements
Module: spio_uart_tx_framer

---
 rtl/spio_uart_tx_framer_pkg.sv | 55 +++++
 rtl/spio_uart_tx_pkt_fifo.sv | 65 ++++++
 rtl/spio_uart_tx_framer.sv | 195 +++++++++++++++++++
 tb/tb_spio_uart_tx_framer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spio_uart_tx_framer_pkg.sv
// Shared types, constants and helpers for the SpiNNaker UART transmit framer.
// The packet-length macros mirror the shared spio_uart_common.h definitions.

`ifndef SPIO_UART_COMMON_H
`define SPIO_UART_COMMON_H
`define PKT_LEN  72
`define SPKT_LEN 40
`endif

package spio_uart_tx_framer_pkg;

    localparam int PKT_LEN  = `PKT_LEN;
    localparam int SPKT_LEN = `SPKT_LEN;

    // FIFO word: {long flag, packet}
    localparam int WORD_LEN = PKT_LEN + 1;

    // FSM state encodings
    localparam logic [2:0] ST_RESET     = 3'd0;
    localparam logic [2:0] ST_IDLE      = 3'd1;
    localparam logic [2:0] ST_PKT       = 3'd2;
    localparam logic [2:0] ST_SYNC_NULL = 3'd3;
    localparam logic [2:0] ST_SYNC_END  = 3'd4;

    typedef enum logic [2:0] {
        S_RESET     = ST_RESET,
        S_IDLE      = ST_IDLE,
        S_PKT       = ST_PKT,
        S_SYNC_NULL = ST_SYNC_NULL,
        S_SYNC_END  = ST_SYNC_END
    } state_e;

    // Odd parity over the packet's real length; bit 1 selects long/short.
    function automatic logic pkt_parity_ok(input logic [PKT_LEN-1:0] pkt);
        logic par;
        if (pkt[1]) begin
            par = ^pkt;
        end else begin
            par = ^pkt[SPKT_LEN-1:0];
        end
        return par;
    endfunction

    // Index of the final byte of a packet (5 or 9 bytes).
    function automatic logic [3:0] last_byte_idx(input logic is_long);
        logic [3:0] idx;
        if (is_long) begin
            idx = 4'd8;
        end else begin
            idx = 4'd4;
        end
        return idx;
    endfunction

endpackage

// File: rtl/spio_uart_tx_pkt_fifo.sv
// Small packet buffer for the UART transmit framer: power-of-two depth,
// first-word-fall-through read port, occupancy level output.

module spio_uart_tx_pkt_fifo
    import spio_uart_tx_framer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    push_i,
    input  logic [WORD_LEN-1:0]     wdata_i,
    input  logic                    pop_i,
    output logic [WORD_LEN-1:0]     rdata_o,
    output logic [$clog2(DEPTH):0]  level_o,
    output logic                    full_o,
    output logic                    empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

    logic [WORD_LEN-1:0] mem_q [DEPTH];
    logic [AW-1:0]       wr_ptr_q;
    logic [AW-1:0]       rd_ptr_q;
    logic [AW:0]         level_q;
    logic                do_push_s;
    logic                do_pop_s;

    assign full_o    = (level_q == LVL_FULL);
    assign empty_o   = (level_q == '0);
    assign do_push_s = push_i && !full_o;
    assign do_pop_s  = pop_i && !empty_o;
    assign rdata_o   = mem_q[rd_ptr_q];
    assign level_o   = level_q;

    // Storage array: written only on an accepted push, contents need no reset
    always_ff @(posedge clk_i) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointers and occupancy; a simultaneous push and pop keeps the level
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop_s) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/spio_uart_tx_framer.sv
// SpiNNaker UART transmit framer: buffers packets, serialises them LSB byte
// first, and inserts NULL/end-byte sync sequences on request or periodically.

module spio_uart_tx_framer
    import spio_uart_tx_framer_pkg::*;
#(
    parameter int unsigned NULLS_TO_SEND    = 32'd13,
    parameter logic [7:0]  SYNC_END_BYTE    = 8'hFF,
    parameter int unsigned AUTO_SYNC_PERIOD = 32'd0,
    parameter int          FIFO_DEPTH       = 4,
    parameter bit          CHECK_PARITY     = 1'b1
) (
    input  logic                          CLK_IN,
    input  logic                          RESET_IN,
    input  logic                          SYNC_TRIGGER_IN,
    output logic                          SYNCHRONISING_OUT,
    input  logic [PKT_LEN-1:0]            PKT_DATA_IN,
    input  logic                          PKT_VLD_IN,
    output logic                          PKT_RDY_OUT,
    output logic                          PKT_DROPPED_OUT,
    output logic [7:0]                    BYTE_DATA_OUT,
    output logic                          BYTE_VLD_OUT,
    input  logic                          BYTE_RDY_IN,
    output logic                          PKT_SENT_OUT,
    output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL_OUT
);

    localparam logic [7:0]  NULL_LAST = 8'(NULLS_TO_SEND - 32'd1);
    localparam logic [15:0] AUTO_P    = 16'(AUTO_SYNC_PERIOD);

    state_e              state_q;
    logic [PKT_LEN-1:0]  shift_q;
    logic                long_q;
    logic [3:0]          idx_q;
    logic [7:0]          null_cnt_q;
    logic [7:0]          byte_q;
    logic                byte_vld_q;
    logic                sync_pend_q;
    logic [15:0]         auto_cnt_q;
    logic                dropped_q;

    logic                xfer_s;
    logic                par_ok_s;
    logic                push_s;
    logic                pop_s;
    logic                hs_s;
    logic                sent_s;
    logic                enter_end_s;
    logic                sync_done_s;
    logic                auto_fire_s;
    logic                fifo_full_s;
    logic                fifo_empty_s;
    logic [WORD_LEN-1:0] head_s;

    assign xfer_s      = PKT_VLD_IN && PKT_RDY_OUT;
    assign par_ok_s    = pkt_parity_ok(PKT_DATA_IN);
    assign push_s      = xfer_s && (par_ok_s || !CHECK_PARITY);
    assign pop_s       = (state_q == S_IDLE) && !sync_pend_q && !fifo_empty_s;
    assign hs_s        = byte_vld_q && BYTE_RDY_IN;
    assign sent_s      = hs_s && (state_q == S_PKT) && (idx_q == last_byte_idx(long_q));
    assign enter_end_s = hs_s && (state_q == S_SYNC_NULL) && (null_cnt_q == NULL_LAST);
    assign sync_done_s = hs_s && (state_q == S_SYNC_END);
    assign auto_fire_s = sent_s && (AUTO_P != 16'd0) && ((auto_cnt_q + 16'd1) == AUTO_P);

    assign PKT_RDY_OUT       = (state_q != S_RESET) && !fifo_full_s;
    assign PKT_DROPPED_OUT   = dropped_q;
    assign PKT_SENT_OUT      = sent_s;
    assign BYTE_DATA_OUT     = byte_q;
    assign BYTE_VLD_OUT      = byte_vld_q;
    assign SYNCHRONISING_OUT = sync_pend_q || (state_q == S_SYNC_NULL) || (state_q == S_SYNC_END);

    spio_uart_tx_pkt_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (CLK_IN),
        .rst_i   (RESET_IN),
        .push_i  (push_s),
        .wdata_i ({PKT_DATA_IN[1], PKT_DATA_IN}),
        .pop_i   (pop_s),
        .rdata_o (head_s),
        .level_o (FIFO_LEVEL_OUT),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s)
    );

    // Flag a parity-rejected packet one cycle after its handshake
    always_ff @(posedge CLK_IN or posedge RESET_IN) begin
        if (RESET_IN) begin
            dropped_q <= 1'b0;
        end else begin
            dropped_q <= xfer_s && !par_ok_s && CHECK_PARITY;
        end
    end

    // Sync-pending flag: a new request wins over the clear on entering SYNC_END
    always_ff @(posedge CLK_IN or posedge RESET_IN) begin
        if (RESET_IN) begin
            sync_pend_q <= 1'b0;
        end else if (SYNC_TRIGGER_IN || auto_fire_s) begin
            sync_pend_q <= 1'b1;
        end else if (enter_end_s) begin
            sync_pend_q <= 1'b0;
        end else begin
            sync_pend_q <= sync_pend_q;
        end
    end

    // Packets-since-sync counter driving the automatic sync
    always_ff @(posedge CLK_IN or posedge RESET_IN) begin
        if (RESET_IN) begin
            auto_cnt_q <= 16'd0;
        end else if (sync_done_s || auto_fire_s) begin
            auto_cnt_q <= 16'd0;
        end else if (sent_s) begin
            auto_cnt_q <= auto_cnt_q + 16'd1;
        end else begin
            auto_cnt_q <= auto_cnt_q;
        end
    end

    // Framing FSM with registered byte outputs; data only advances on a handshake
    always_ff @(posedge CLK_IN or posedge RESET_IN) begin
        if (RESET_IN) begin
            state_q    <= S_RESET;
            shift_q    <= '0;
            long_q     <= 1'b0;
            idx_q      <= 4'd0;
            null_cnt_q <= 8'd0;
            byte_q     <= 8'h00;
            byte_vld_q <= 1'b0;
        end else begin
            case (state_q)
                S_RESET: begin
                    state_q    <= S_IDLE;
                    byte_q     <= 8'h00;
                    byte_vld_q <= 1'b0;
                end
                S_IDLE: begin
                    if (sync_pend_q) begin
                        state_q    <= S_SYNC_NULL;
                        null_cnt_q <= 8'd0;
                        byte_q     <= 8'h00;
                        byte_vld_q <= 1'b1;
                    end else if (!fifo_empty_s) begin
                        state_q    <= S_PKT;
                        shift_q    <= head_s[PKT_LEN-1:0];
                        long_q     <= head_s[PKT_LEN];
                        idx_q      <= 4'd0;
                        byte_q     <= head_s[7:0];
                        byte_vld_q <= 1'b1;
                    end else begin
                        byte_q     <= 8'h00;
                        byte_vld_q <= 1'b0;
                    end
                end
                S_PKT: begin
                    if (BYTE_RDY_IN) begin
                        if (idx_q == last_byte_idx(long_q)) begin
                            state_q    <= S_IDLE;
                            byte_q     <= 8'h00;
                            byte_vld_q <= 1'b0;
                        end else begin
                            idx_q   <= idx_q + 4'd1;
                            shift_q <= {8'h00, shift_q[PKT_LEN-1:8]};
                            byte_q  <= shift_q[15:8];
                        end
                    end
                end
                S_SYNC_NULL: begin
                    if (BYTE_RDY_IN) begin
                        if (null_cnt_q == NULL_LAST) begin
                            state_q <= S_SYNC_END;
                            byte_q  <= SYNC_END_BYTE;
                        end else begin
                            null_cnt_q <= null_cnt_q + 8'd1;
                        end
                    end
                end
                S_SYNC_END: begin
                    if (BYTE_RDY_IN) begin
                        state_q    <= S_IDLE;
                        byte_q     <= 8'h00;
                        byte_vld_q <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= S_IDLE;
                    byte_q     <= 8'h00;
                    byte_vld_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spio_uart_tx_framer.sv
// Directed bench for spio_uart_tx_framer: instance A uses the defaults,
// instance B uses AUTO_SYNC_PERIOD=3, CHECK_PARITY=0 and a 2-NULL sync.

module tb_spio_uart_tx_framer;

    logic        clk = 1'b0;
    logic        rst;

    logic        a_sync, a_synch, a_pvld, a_prdy, a_drop, a_bvld, a_brdy, a_sent;
    logic [71:0] a_pdata;
    logic [7:0]  a_bdata;
    logic [2:0]  a_lvl;

    logic        b_sync, b_synch, b_pvld, b_prdy, b_drop, b_bvld, b_brdy, b_sent;
    logic [71:0] b_pdata;
    logic [7:0]  b_bdata;
    logic [2:0]  b_lvl;

    // short packet 12_3456_7001 (13 ones), long packet with 27 ones
    localparam logic [71:0] PKT_S   = 72'h00_0000_0000_1234_567001;
    localparam logic [71:0] PKT_L   = 72'h88_7766_5544_3322_1102;
    localparam logic [71:0] PKT_BAD = 72'h00_0000_0000_0000_000005;

    logic [7:0]  pb0 [6] = '{8'h01, 8'h10, 8'h20, 8'h40, 8'h80, 8'h04};

    int          n_tests = 0;
    int          n_fail  = 0;

    logic [7:0]  qa [$];
    logic [7:0]  qb [$];
    logic [7:0]  expq [$];
    int          sent_a = 0, sent_b = 0, drop_a = 0, drop_b = 0;
    int          stall_bad_a = 0, stall_bad_b = 0;
    logic        prev_stall_a = 1'b0, prev_stall_b = 1'b0;
    logic [7:0]  prev_data_a = 8'h00, prev_data_b = 8'h00;

    always #5 clk = ~clk;

    spio_uart_tx_framer dut_a (
        .CLK_IN (clk), .RESET_IN (rst),
        .SYNC_TRIGGER_IN (a_sync), .SYNCHRONISING_OUT (a_synch),
        .PKT_DATA_IN (a_pdata), .PKT_VLD_IN (a_pvld), .PKT_RDY_OUT (a_prdy),
        .PKT_DROPPED_OUT (a_drop),
        .BYTE_DATA_OUT (a_bdata), .BYTE_VLD_OUT (a_bvld), .BYTE_RDY_IN (a_brdy),
        .PKT_SENT_OUT (a_sent), .FIFO_LEVEL_OUT (a_lvl)
    );

    spio_uart_tx_framer #(
        .NULLS_TO_SEND (32'd2), .AUTO_SYNC_PERIOD (32'd3), .CHECK_PARITY (1'b0)
    ) dut_b (
        .CLK_IN (clk), .RESET_IN (rst),
        .SYNC_TRIGGER_IN (b_sync), .SYNCHRONISING_OUT (b_synch),
        .PKT_DATA_IN (b_pdata), .PKT_VLD_IN (b_pvld), .PKT_RDY_OUT (b_prdy),
        .PKT_DROPPED_OUT (b_drop),
        .BYTE_DATA_OUT (b_bdata), .BYTE_VLD_OUT (b_bvld), .BYTE_RDY_IN (b_brdy),
        .PKT_SENT_OUT (b_sent), .FIFO_LEVEL_OUT (b_lvl)
    );

    // Byte/pulse collectors and stall-stability watchers, sampled mid-cycle
    always @(negedge clk) begin
        if (a_bvld && a_brdy) qa.push_back(a_bdata);
        if (b_bvld && b_brdy) qb.push_back(b_bdata);
        if (a_sent) sent_a <= sent_a + 1;
        if (b_sent) sent_b <= sent_b + 1;
        if (a_drop) drop_a <= drop_a + 1;
        if (b_drop) drop_b <= drop_b + 1;
        if (prev_stall_a && (!a_bvld || a_bdata != prev_data_a)) stall_bad_a <= stall_bad_a + 1;
        if (prev_stall_b && (!b_bvld || b_bdata != prev_data_b)) stall_bad_b <= stall_bad_b + 1;
        prev_stall_a <= a_bvld && !a_brdy;
        prev_stall_b <= b_bvld && !b_brdy;
        prev_data_a  <= a_bdata;
        prev_data_b  <= b_bdata;
    end

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Offer one packet to instance A (sel=0) or B (sel=1), waiting for ready
    task automatic push(input bit sel, input logic [71:0] pkt);
        int guard = 0;
        while (!(sel ? b_prdy : a_prdy) && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 200) check("push_timeout", sel ? b_prdy : a_prdy, 1'b1);
        if (sel) begin b_pdata = pkt; b_pvld = 1'b1; end
        else     begin a_pdata = pkt; a_pvld = 1'b1; end
        @(posedge clk); #1;
        a_pvld = 1'b0;
        b_pvld = 1'b0;
    endtask

    task automatic add_pkt(input logic [71:0] pkt, input int nbytes);
        for (int i = 0; i < nbytes; i++) expq.push_back(pkt[8*i +: 8]);
    endtask

    task automatic cmp_a(input string tag, input int base);
        check({tag, "_len"}, qa.size() - base, expq.size());
        for (int i = 0; i < expq.size(); i++)
            if (base + i < qa.size()) check(tag, qa[base + i], expq[i]);
    endtask

    task automatic cmp_b(input string tag, input int base);
        check({tag, "_len"}, qb.size() - base, expq.size());
        for (int i = 0; i < expq.size(); i++)
            if (base + i < qb.size()) check(tag, qb[base + i], expq[i]);
    endtask

    initial begin
        int base, s0, d0, st0, bad, found;
        rst = 1'b1;
        a_sync = 1'b0; a_pvld = 1'b0; a_brdy = 1'b0; a_pdata = '0;
        b_sync = 1'b0; b_pvld = 1'b0; b_brdy = 1'b0; b_pdata = '0;
        cycles(3);

        // reset state
        check("rst_pkt_rdy", a_prdy, 1'b0);
        check("rst_byte_vld", a_bvld, 1'b0);
        check("rst_level", a_lvl, 3'd0);
        check("rst_synch", a_synch, 1'b0);
        check("rst_data", a_bdata, 8'h00);
        rst = 1'b0;
        #1;
        check("rdy_low_reset_state", a_prdy, 1'b0);
        cycles(1);
        check("rdy_after_reset", a_prdy, 1'b1);

        // short packet, ready held high, first byte at N+2
        a_brdy = 1'b1;
        base = qa.size(); s0 = sent_a;
        push(1'b0, PKT_S);
        check("t1_vld_n1", a_bvld, 1'b0);
        check("t1_level_n1", a_lvl, 3'd1);
        cycles(1);
        check("t1_vld_n2", a_bvld, 1'b1);
        check("t1_byte0_n2", a_bdata, 8'h01);
        cycles(10);
        expq = '{8'h01, 8'h70, 8'h56, 8'h34, 8'h12};
        cmp_a("t1_byte", base);
        check("t1_sent", sent_a - s0, 1);

        // long packet with ready toggling
        a_brdy = 1'b0;
        base = qa.size(); s0 = sent_a; st0 = stall_bad_a;
        push(1'b0, PKT_L);
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            a_brdy = ~a_brdy;
        end
        a_brdy = 1'b1;
        cycles(3);
        expq = '{8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        cmp_a("t2_byte", base);
        check("t2_sent", sent_a - s0, 1);
        check("t2_stable", stall_bad_a - st0, 0);

        // bad parity dropped
        base = qa.size(); d0 = drop_a;
        push(1'b0, PKT_BAD);
        check("t3_drop_pulse", a_drop, 1'b1);
        check("t3_level", a_lvl, 3'd0);
        cycles(1);
        check("t3_drop_single", a_drop, 1'b0);
        cycles(8);
        check("t3_no_bytes", qa.size() - base, 0);
        check("t3_drop_count", drop_a - d0, 1);

        // sync requested mid-packet
        base = qa.size();
        push(1'b0, PKT_S);
        cycles(2);
        a_sync = 1'b1;
        cycles(1);
        a_sync = 1'b0;
        check("t4_synch_on", a_synch, 1'b1);
        bad = 0; found = 0;
        for (int i = 0; i < 80 && found == 0; i++) begin
            @(negedge clk);
            if (!a_synch) bad++;
            if (a_bvld && a_brdy && a_bdata == 8'hFF) found = 1;
        end
        check("t4_synch_held", bad, 0);
        check("t4_end_seen", found, 1);
        cycles(1);
        check("t4_synch_off", a_synch, 1'b0);
        cycles(2);
        expq = '{8'h01, 8'h70, 8'h56, 8'h34, 8'h12};
        for (int i = 0; i < 13; i++) expq.push_back(8'h00);
        expq.push_back(8'hFF);
        cmp_a("t4_stream", base);

        // instance B: fill FIFO, auto sync every 3 packets
        b_brdy = 1'b0;
        base = qb.size(); s0 = sent_b; st0 = stall_bad_b;
        push(1'b1, {64'h0, pb0[0]});
        push(1'b1, {64'h0, pb0[1]});
        check("t5_level_simul", b_lvl, 3'd1);
        push(1'b1, {64'h0, pb0[2]});
        push(1'b1, {64'h0, pb0[3]});
        push(1'b1, {64'h0, pb0[4]});
        check("t5_level_full", b_lvl, 3'd4);
        check("t5_rdy_full", b_prdy, 1'b0);
        cycles(3);
        check("t5_rdy_stays_low", b_prdy, 1'b0);
        b_brdy = 1'b1;
        push(1'b1, {64'h0, pb0[5]});
        cycles(80);
        expq.delete();
        for (int i = 0; i < 6; i++) begin
            add_pkt({64'h0, pb0[i]}, 5);
            if (i == 2 || i == 5) begin
                expq.push_back(8'h00); expq.push_back(8'h00); expq.push_back(8'hFF);
            end
        end
        cmp_b("t5_stream", base);
        check("t5_sent", sent_b - s0, 6);
        check("t5_level_end", b_lvl, 3'd0);
        check("t5_stable", stall_bad_b - st0, 0);

        // instance B: bad parity passes when checking is off, no auto sync yet
        base = qb.size(); d0 = drop_b;
        push(1'b1, PKT_BAD);
        cycles(12);
        expq = '{8'h05, 8'h00, 8'h00, 8'h00, 8'h00};
        cmp_b("t6_nocheck", base);
        check("t6_no_drop", drop_b - d0, 0);
        check("t6_no_sync", b_synch, 1'b0);

        // reset mid-packet with another packet buffered
        a_brdy = 1'b0;
        push(1'b0, PKT_L);
        push(1'b0, PKT_S);
        check("t7_level_pre", a_lvl, 3'd1);
        a_brdy = 1'b1;
        cycles(1);
        check("t7_vld_pre", a_bvld, 1'b1);
        rst = 1'b1;
        #1;
        check("t7_vld_now", a_bvld, 1'b0);
        check("t7_level_now", a_lvl, 3'd0);
        check("t7_rdy_now", a_prdy, 1'b0);
        check("t7_data_now", a_bdata, 8'h00);
        check("t7_sent_now", a_sent, 1'b0);
        base = qa.size();
        cycles(2);
        rst = 1'b0;
        #1;
        check("t7_rdy_release", a_prdy, 1'b0);
        cycles(1);
        check("t7_rdy_after", a_prdy, 1'b1);
        cycles(10);
        check("t7_no_bytes", qa.size() - base, 0);
        check("t7_level_after", a_lvl, 3'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
